// File: rtl/mem_arbiter_if.sv
// Bundle of requester, bus and status signals around the I/D memory arbiter.
// master is the arbiter's view; slave is the environment (fetch, LSU, memory controller).
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_busy;
  logic [31:0] bus_rdata;
  logic [1:0]  owner;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_busy, bus_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, err, bus_addr, bus_wdata, bus_rd, bus_wr, owner
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_busy, bus_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, err, bus_addr, bus_wdata, bus_rd, bus_wr, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one memory port:
// D has priority, I is forced through after STARVE_LIMIT back-to-back D wins, bus stalls time out.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master arb
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [1:0]    OWN_NONE   = 2'b00;
  localparam logic [1:0]    OWN_I      = 2'b01;
  localparam logic [1:0]    OWN_D      = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [1:0]    owner_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic          bus_rd_q, bus_wr_q;
  logic          i_ack_q, d_ack_q, err_q;
  logic [31:0]   i_rdata_q, d_rdata_q;

  logic          pick_i_d, pick_d_d;
  logic [31:0]   rdata_d;

  always_comb begin
    pick_i_d = arb.i_req && (!arb.d_req || starve_q == STARVE_MAX);
    pick_d_d = arb.d_req && !pick_i_d;
    rdata_d  = we_q ? 32'h0 : arb.bus_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      starve_q  <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_rd_q  <= 1'b0;
      bus_wr_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      // strobes and response pulses are single-cycle unless re-armed below
      bus_rd_q  <= 1'b0;
      bus_wr_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_i_d) begin
            owner_q  <= OWN_I;
            addr_q   <= arb.i_addr;
            we_q     <= 1'b0;
            starve_q <= '0;
            bus_rd_q <= 1'b1;
            state_q  <= ISSUE;
          end else if (pick_d_d) begin
            owner_q  <= OWN_D;
            addr_q   <= arb.d_addr;
            wdata_q  <= arb.d_wdata;
            we_q     <= arb.d_we;
            bus_rd_q <= !arb.d_we;
            bus_wr_q <= arb.d_we;
            if (arb.i_req && starve_q != STARVE_MAX)
              starve_q <= starve_q + SW'(1);
            state_q  <= ISSUE;
          end else begin
            owner_q <= OWN_NONE;
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!arb.bus_busy) begin
            i_ack_q   <= (owner_q == OWN_I);
            d_ack_q   <= (owner_q == OWN_D);
            i_rdata_q <= (owner_q == OWN_I) ? rdata_d : 32'h0;
            d_rdata_q <= (owner_q == OWN_D) ? rdata_d : 32'h0;
            state_q   <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            i_ack_q <= (owner_q == OWN_I);
            d_ack_q <= (owner_q == OWN_D);
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          owner_q <= OWN_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.i_ack     = i_ack_q;
  assign arb.i_rdata   = i_rdata_q;
  assign arb.d_ack     = d_ack_q;
  assign arb.d_rdata   = d_rdata_q;
  assign arb.err       = err_q;
  assign arb.bus_addr  = addr_q;
  assign arb.bus_wdata = wdata_q;
  assign arb.bus_rd    = bus_rd_q;
  assign arb.bus_wr    = bus_wr_q;
  assign arb.owner     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected responses are queued at stimulus time and
// popped when an ack appears.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if arb();

  mem_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(64)) dut (
    .clk(clk),
    .rst(rst),
    .arb(arb)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int n, output bit got);
    n = 0; got = 1'b0;
    while (n < budget && !got) begin
      step();
      n++;
      if (arb.i_ack || arb.d_ack) got = 1'b1;
    end
  endtask

  task automatic wait_strobe(input int budget, output int n, output bit got);
    n = 0; got = 1'b0;
    while (n < budget && !got) begin
      step();
      n++;
      if (arb.bus_rd || arb.bus_wr) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    int n;
    tests++;
    if ({arb.i_ack, arb.d_ack, arb.err, arb.bus_rd, arb.bus_wr, arb.owner,
         arb.bus_addr, arb.bus_wdata, arb.i_rdata, arb.d_rdata} !== '0) begin
      fails++; $display("FAIL reset_init: outputs not all zero, owner=%b", arb.owner);
    end
    #3 rst = 1'b1;
    arb.d_req = 1'b1; arb.d_we = 1'b0; arb.d_addr = 32'h40; arb.bus_busy = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    #1;
    tests++;
    if ({arb.i_ack, arb.d_ack, arb.err, arb.bus_rd, arb.bus_wr, arb.owner,
         arb.bus_addr, arb.bus_wdata, arb.i_rdata, arb.d_rdata} !== '0) begin
      fails++; $display("FAIL reset_wait: outputs not zero, owner=%b d_ack=%b addr=%h",
                        arb.owner, arb.d_ack, arb.bus_addr);
    end
    arb.d_req = 1'b0; arb.bus_busy = 1'b0;
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if ({arb.owner, arb.bus_rd, arb.bus_wr, arb.d_ack, arb.i_ack} !== 6'b0) begin
        fails++; $display("FAIL reset_idle[%0d]: owner=%b rd=%b wr=%b d_ack=%b, want idle",
                          k, arb.owner, arb.bus_rd, arb.bus_wr, arb.d_ack);
      end
    end
  endtask

  task automatic test_lone_d_read();
    exp_t e;
    arb.d_req = 1'b1; arb.d_we = 1'b0; arb.d_addr = 32'h100;
    arb.bus_busy = 1'b0; arb.bus_rdata = 32'hDEADBEEF;
    sb.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    step();
    tests++;
    if ({arb.bus_rd, arb.bus_wr, arb.bus_addr, arb.owner} !== {2'b10, 32'h100, 2'b10}) begin
      fails++; $display("FAIL rd_issue: rd=%b wr=%b addr=%h owner=%b, want rd=1 wr=0 addr=100 owner=10",
                        arb.bus_rd, arb.bus_wr, arb.bus_addr, arb.owner);
    end
    step();
    tests++;
    if ({arb.bus_rd, arb.d_ack} !== 2'b00) begin
      fails++; $display("FAIL rd_wait: rd=%b d_ack=%b, want 0 0", arb.bus_rd, arb.d_ack);
    end
    step();
    e = sb.pop_front();
    tests++;
    if ({arb.d_ack, arb.i_ack, arb.d_rdata, arb.err} !== {1'b1, 1'b0, e.rdata, e.err}) begin
      fails++; $display("FAIL rd_ack_cycle3: d_ack=%b i_ack=%b d_rdata=%h err=%b, want 1 0 %h %b",
                        arb.d_ack, arb.i_ack, arb.d_rdata, arb.err, e.rdata, e.err);
    end
    arb.d_req = 1'b0;
    step();
    tests++;
    if ({arb.d_ack, arb.d_rdata} !== 33'h0) begin
      fails++; $display("FAIL rd_ack_pulse: d_ack=%b d_rdata=%h after RESP, want 0", arb.d_ack, arb.d_rdata);
    end
  endtask

  task automatic test_lone_d_write();
    exp_t e; int n; bit got;
    arb.d_req = 1'b1; arb.d_we = 1'b1; arb.d_addr = 32'h20; arb.d_wdata = 32'h55;
    arb.bus_busy = 1'b1; arb.bus_rdata = 32'hFFFF_FFFF;
    sb.push_back('{1'b1, 32'h0, 1'b0});
    wait_strobe(4, n, got);
    tests++;
    if ({got, arb.bus_wr, arb.bus_rd, arb.bus_addr, arb.bus_wdata} !== {3'b110, 32'h20, 32'h55}) begin
      fails++; $display("FAIL wr_issue: got=%b wr=%b rd=%b addr=%h wdata=%h, want 1 1 0 20 55",
                        got, arb.bus_wr, arb.bus_rd, arb.bus_addr, arb.bus_wdata);
    end
    arb.d_addr = 32'h99; arb.d_wdata = 32'h77; arb.d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      tests++;
      if ({arb.bus_wr, arb.bus_rd, arb.d_ack, arb.bus_addr, arb.bus_wdata} !== {3'b000, 32'h20, 32'h55}) begin
        fails++; $display("FAIL wr_busy[%0d]: wr=%b rd=%b d_ack=%b addr=%h wdata=%h, want 0 0 0 20 55",
                          k, arb.bus_wr, arb.bus_rd, arb.d_ack, arb.bus_addr, arb.bus_wdata);
      end
    end
    arb.bus_busy = 1'b0;
    wait_ack(5, n, got);
    e = sb.pop_front();
    tests++;
    if ({got, n, arb.d_ack, arb.i_ack, arb.d_rdata, arb.err} !== {1'b1, 32'd1, 2'b10, e.rdata, e.err}) begin
      fails++; $display("FAIL wr_ack: got=%b n=%0d d_ack=%b d_rdata=%h err=%b, want 1 1 1 %h %b",
                        got, n, arb.d_ack, arb.d_rdata, arb.err, e.rdata, e.err);
    end
    arb.d_req = 1'b0; arb.d_we = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    exp_t e; int n; bit got; int cnt; logic want_d;
    cnt = 0;
    arb.i_req = 1'b1; arb.i_addr = 32'h1000;
    arb.d_req = 1'b1; arb.d_we = 1'b0; arb.d_addr = 32'h2000;
    arb.bus_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (cnt == 3) begin want_d = 1'b0; cnt = 0; end
      else begin want_d = 1'b1; cnt++; end
      wait_strobe(4, n, got);
      arb.bus_rdata = 32'hA000_0000 + k;
      sb.push_back('{want_d, 32'hA000_0000 + k, 1'b0});
      tests++;
      if (!got || (k > 0 && n != 2) ||
          arb.owner !== (want_d ? 2'b10 : 2'b01) ||
          arb.bus_addr !== (want_d ? 32'h2000 : 32'h1000)) begin
        fails++; $display("FAIL starve_grant[%0d]: got=%b gap=%0d owner=%b addr=%h, want owner=%b",
                          k, got, n, arb.owner, arb.bus_addr, want_d ? 2'b10 : 2'b01);
      end
      wait_ack(4, n, got);
      e = sb.pop_front();
      tests++;
      if ({got, arb.d_ack, arb.i_ack, (e.is_d ? arb.d_rdata : arb.i_rdata), arb.err} !==
          {1'b1, e.is_d, !e.is_d, e.rdata, e.err}) begin
        fails++; $display("FAIL starve_ack[%0d]: got=%b d_ack=%b i_ack=%b i_rdata=%h d_rdata=%h, want is_d=%b data=%h",
                          k, got, arb.d_ack, arb.i_ack, arb.i_rdata, arb.d_rdata, e.is_d, e.rdata);
      end
    end
    arb.i_req = 1'b0; arb.d_req = 1'b0;
    step(); step();
  endtask

  task automatic test_timeout();
    exp_t e; int n; bit got;
    arb.i_req = 1'b1; arb.i_addr = 32'h300;
    arb.bus_busy = 1'b1; arb.bus_rdata = 32'hFFFF_FFFF;
    sb.push_back('{1'b0, 32'h0, 1'b1});
    wait_strobe(4, n, got);
    tests++;
    if ({got, arb.bus_rd, arb.owner} !== 4'b1101) begin
      fails++; $display("FAIL tmo_issue: got=%b rd=%b owner=%b, want 1 1 01", got, arb.bus_rd, arb.owner);
    end
    wait_ack(100, n, got);
    e = sb.pop_front();
    tests++;
    if ({got, n, arb.i_ack, arb.d_ack, arb.i_rdata, arb.err} !== {1'b1, 32'd65, 2'b10, e.rdata, e.err}) begin
      fails++; $display("FAIL tmo_ack: got=%b cycles_after_issue=%0d i_ack=%b i_rdata=%h err=%b, want 1 65 1 %h %b",
                        got, n, arb.i_ack, arb.i_rdata, arb.err, e.rdata, e.err);
    end
    arb.i_req = 1'b0; arb.bus_busy = 1'b0;
    step();
    arb.i_req = 1'b1; arb.i_addr = 32'h304; arb.bus_rdata = 32'h12345678;
    sb.push_back('{1'b0, 32'h12345678, 1'b0});
    wait_strobe(4, n, got);
    wait_ack(4, n, got);
    e = sb.pop_front();
    tests++;
    if ({got, n, arb.i_ack, arb.i_rdata, arb.err} !== {1'b1, 32'd2, 1'b1, e.rdata, e.err}) begin
      fails++; $display("FAIL tmo_recover: got=%b n=%0d i_ack=%b i_rdata=%h err=%b, want 1 2 1 %h 0",
                        got, n, arb.i_ack, arb.i_rdata, arb.err, e.rdata);
    end
    arb.i_req = 1'b0;
    step();
  endtask

  task automatic test_drop_req();
    exp_t e; int n; bit got;
    arb.i_req = 1'b1; arb.i_addr = 32'h400; arb.bus_busy = 1'b0; arb.bus_rdata = 32'h0BADF00D;
    sb.push_back('{1'b0, 32'h0BADF00D, 1'b0});
    wait_strobe(4, n, got);
    arb.i_req = 1'b0;
    arb.d_req = 1'b1; arb.d_we = 1'b0; arb.d_addr = 32'h500;
    wait_ack(4, n, got);
    e = sb.pop_front();
    tests++;
    if ({got, n, arb.i_ack, arb.d_ack, arb.i_rdata} !== {1'b1, 32'd2, 2'b10, e.rdata}) begin
      fails++; $display("FAIL drop_i_ack: got=%b n=%0d i_ack=%b d_ack=%b i_rdata=%h, want 1 2 1 0 %h",
                        got, n, arb.i_ack, arb.d_ack, arb.i_rdata, e.rdata);
    end
    arb.bus_rdata = 32'hCAFE0001;
    sb.push_back('{1'b1, 32'hCAFE0001, 1'b0});
    wait_strobe(4, n, got);
    tests++;
    if ({got, n, arb.owner, arb.bus_addr} !== {1'b1, 32'd2, 2'b10, 32'h500}) begin
      fails++; $display("FAIL drop_d_grant: got=%b gap=%0d owner=%b addr=%h, want 1 2 10 500",
                        got, n, arb.owner, arb.bus_addr);
    end
    wait_ack(4, n, got);
    e = sb.pop_front();
    tests++;
    if ({got, arb.d_ack, arb.d_rdata, arb.err} !== {2'b11, e.rdata, e.err}) begin
      fails++; $display("FAIL drop_d_ack: got=%b d_ack=%b d_rdata=%h err=%b, want 1 1 %h 0",
                        got, arb.d_ack, arb.d_rdata, arb.err, e.rdata);
    end
    arb.d_req = 1'b0;
    step();
  endtask

  initial begin
    arb.i_req = 1'b0; arb.i_addr = '0;
    arb.d_req = 1'b0; arb.d_we = 1'b0; arb.d_addr = '0; arb.d_wdata = '0;
    arb.bus_busy = 1'b0; arb.bus_rdata = '0;
    #1;
    test_reset();
    test_lone_d_read();
    test_lone_d_write();
    test_starvation();
    test_timeout();
    test_drop_req();
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single memory/bus port between instruction fetch (I) and data load/store (D) in the RV32I core.
- Sits between the fetch/LSU stages and the memory controller.
- Serialises one transaction at a time, with D priority and an anti-starvation guarantee for I.
- Adds a bus timeout with an error response.

Parameters:
STARVE_LIMIT, 3, consecutive D grants made while I is pending before I is forced to win.
TIMEOUT, 64, maximum cycles spent in WAIT with bus_busy high before the transaction is aborted.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
i_req  in  1  instruction fetch request; held until i_ack
i_addr  in  32  fetch address
i_ack  out  1  one-cycle response pulse to I
i_rdata  out  32  fetched word; valid only while i_ack=1, otherwise 0
d_req  in  1  data request; held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  32  data address
d_wdata  in  32  store data
d_ack  out  1  one-cycle response pulse to D
d_rdata  out  32  load data; valid while d_ack=1 on a read, otherwise 0
err  out  1  pulses with the ack when the transaction timed out
bus_addr  out  32  latched address to memory controller
bus_wdata  out  32  latched store data
bus_rd  out  1  one-cycle read strobe
bus_wr  out  1  one-cycle write strobe
bus_busy  in  1  memory controller busy
bus_rdata  in  32  read data, valid when bus_busy=0 in WAIT
owner  out  2  00 none, 01 I, 10 D; current transaction owner

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, owner=00, starve_cnt=0.
  - All outputs 0; latched addr/wdata/we cleared.
  - Any in-flight transaction is discarded with no ack.
- All outputs are registered.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration on a clock edge:
  - Only one request: that requester wins.
  - Both requesting: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
  - Winner's address, wdata and we (I is always a read) are latched; owner is set; next state is ISSUE.
  - No request: stay in IDLE, owner=00.
- Starvation counter:
  - D grant while i_req=1: starve_cnt += 1, saturating at STARVE_LIMIT.
  - Any I grant: starve_cnt := 0.
  - D grant with i_req=0: no change.
- ISSUE:
  - bus_addr/bus_wdata are driven from the latches.
  - Exactly one of bus_rd/bus_wr pulses for this single cycle.
  - Always go to WAIT; the timeout counter is cleared.
- WAIT:
  - bus_busy=0: capture bus_rdata (reads only) and go to RESP.
  - bus_busy=1: increment the timeout counter.
  - Counter reaching TIMEOUT: go to RESP with the error flag set and captured data 0.
- RESP (single cycle):
  - The owner's ack=1; its rdata = captured data (0 for writes and for errors).
  - err = error flag; then return to IDLE with owner=00.
  - Requests are not sampled in RESP.
- Latency: a request first seen in IDLE at edge 0 gives ISSUE at cycle 1 and WAIT at cycle 2. If bus_busy=0 at cycle 2, the ack is in cycle 3 (minimum 3 cycles, request to ack).
- Requester drops req mid-transaction: the transaction still completes and the ack still pulses.
- Inputs are ignored after latching: changes to addr/wdata/we after the grant do not affect the bus.
- bus_addr/bus_wdata hold their last values outside ISSUE/WAIT. Consumers qualify them only with the strobes.
- Back-to-back: a requester that keeps req high after its ack is re-arbitrated in the following IDLE cycle (one idle cycle between transactions).
- The arbiter never asserts bus_rd and bus_wr together, and never issues a strobe outside ISSUE.

Test Plan:
- Reset during WAIT (D read pending, bus_busy=1) -> owner=00, no d_ack, all outputs 0; after release with d_req=0 and i_req=0, state stays IDLE.
- Lone D read: d_addr=0x100, bus_busy=0, bus_rdata=0xDEADBEEF -> bus_rd pulse at cycle 1 with bus_addr=0x100; d_ack=1, d_rdata=0xDEADBEEF at cycle 3; i_ack stays 0.
- Lone D write: d_addr=0x20, d_wdata=0x55, bus_busy high 4 cycles -> bus_wr one cycle with bus_wdata=0x55; d_ack after busy falls, d_rdata=0, err=0.
- I and D both held high, D re-requesting after each ack, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; owner sequence matches; starve_cnt returns to 0 after each I grant.
- bus_busy stuck high, TIMEOUT=64, I read -> i_ack with err=1 and i_rdata=0 exactly 64 WAIT cycles after ISSUE; next request proceeds normally.
- I request dropped the cycle after grant, with d_req raised -> I transaction completes (i_ack pulses); D granted in the following IDLE cycle.
